// File: rtl/md_issue_ctrl_if.sv
// Requester/responder bundle between the E-stage MD issuer and the
// multiply/divide unit: command (master) out, busy and HI/LO (slave) back.
//
// Signals:
//   md_start  start strobe for mult/multu/div/divu
//   md_op     operation code (mult/multu/div/divu, 0 when idle)
//   md_mthi   mthi write strobe (HI <= md_a)
//   md_mtlo   mtlo write strobe (LO <= md_a)
//   md_a/md_b operands A (rs) and B (rt)
//   md_busy   MD unit is computing
//   md_hi     HI register of the MD unit
//   md_lo     LO register of the MD unit

`ifndef MD_ISSUE_CTRL_DEFS
`define MD_ISSUE_CTRL_DEFS
`define MD_MULT  3'd1
`define MD_MULTU 3'd2
`define MD_DIV   3'd3
`define MD_DIVU  3'd4
`endif

interface md_issue_ctrl_if;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_mthi;
    logic        md_mtlo;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_start,
        output md_op,
        output md_mthi,
        output md_mtlo,
        output md_a,
        output md_b,
        input  md_busy,
        input  md_hi,
        input  md_lo
    );

    modport slave (
        input  md_start,
        input  md_op,
        input  md_mthi,
        input  md_mtlo,
        input  md_a,
        input  md_b,
        output md_busy,
        output md_hi,
        output md_lo
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issuer and hazard controller for the multiply/divide unit.
// Issues MD commands, shadows the MD latency, stalls D on MD hazards,
// returns HI/LO for mfhi/mflo and flags start/busy protocol errors.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req             flush/interrupt: suppresses commands this cycle
//   e_valid, e_op   E-stage valid and MD class (0 none .. 8 mflo)
//   e_rs, e_rt      operands A and B
//   d_uses_md       D-stage instruction is an MD-class instruction
//   md              master side of the MD unit bundle
//   e_md_rdata      HI for mfhi, LO for mflo, else 0
//   d_stall         stall D (and freeze F)
//   md_err          sticky protocol-error flag
//   stall_cycles    saturating count of stalled cycles

module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  e_valid,
    input  logic [3:0]            e_op,
    input  logic [31:0]           e_rs,
    input  logic [31:0]           e_rt,
    input  logic                  d_uses_md,
    md_issue_ctrl_if.master       md,
    output logic [31:0]           e_md_rdata,
    output logic                  d_stall,
    output logic                  md_err,
    output logic [31:0]           stall_cycles
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      stall_q, stall_d;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic op_mul_any, op_div_any, op_start;
    logic is_idle, is_wait, issue;
    logic [2:0] op_code;

    // Opcode decode; 9-15 fall out as "none"
    always_comb begin
        op_mult  = (e_op == 4'd1);
        op_multu = (e_op == 4'd2);
        op_div   = (e_op == 4'd3);
        op_divu  = (e_op == 4'd4);
        op_mthi  = (e_op == 4'd5);
        op_mtlo  = (e_op == 4'd6);
        op_mfhi  = (e_op == 4'd7);
        op_mflo  = (e_op == 4'd8);
    end

    assign op_mul_any = op_mult | op_multu;
    assign op_div_any = op_div | op_divu;
    assign op_start   = op_mul_any | op_div_any;

    assign is_idle = (state_q == S_IDLE);
    assign is_wait = (state_q == S_WAIT);

    assign issue = e_valid & op_start & ~req & is_idle;

    always_comb begin
        op_code = 3'd0;
        unique case (1'b1)
            op_mult:  op_code = `MD_MULT;
            op_multu: op_code = `MD_MULTU;
            op_div:   op_code = `MD_DIV;
            op_divu:  op_code = `MD_DIVU;
            default:  op_code = 3'd0;
        endcase
    end

    // Command outputs; forced quiet while reset is held
    always_comb begin
        md.md_start = issue & ~reset;
        md.md_op    = md.md_start ? op_code : 3'd0;
        md.md_mthi  = e_valid & op_mthi & ~req
                    & is_idle & ~reset;
        md.md_mtlo  = e_valid & op_mtlo & ~req
                    & is_idle & ~reset;
        md.md_a     = e_rs;
        md.md_b     = e_rt;
    end

    always_comb begin
        e_md_rdata = 32'd0;
        unique case (1'b1)
            op_mfhi: e_md_rdata = md.md_hi;
            op_mflo: e_md_rdata = md.md_lo;
            default: e_md_rdata = 32'd0;
        endcase
    end

    // The issue term covers the cycle before busy rises;
    // md_busy covers a unit running ahead of our shadow.
    assign d_stall = ~reset & d_uses_md
                   & (is_wait | md.md_busy
                   | (e_valid & op_start & ~req));

    // Latency shadow: a flush during WAIT does not cancel
    // the operation, the MD unit finishes it regardless.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_WAIT;
                    cnt_d   = op_div_any ? CNT_W'(DIV_LAT)
                                         : CNT_W'(MULT_LAT);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky error: busy disagrees with our shadow, or a
    // command arrives while the unit is still occupied.
    always_comb begin
        err_d = err_q;
        if (md.md_busy != is_wait) begin
            err_d = 1'b1;
        end
        if (e_valid & (op_start | op_mthi | op_mtlo)
            & ~req & is_wait) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (d_stall && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign md_err       = err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl with a behavioural MD unit.
// Expectations are queued by the stimulus and checked by a monitor.

module tb_md_issue_ctrl;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    localparam int S_START = 0;
    localparam int S_OP    = 1;
    localparam int S_MTHI  = 2;
    localparam int S_MTLO  = 3;
    localparam int S_STALL = 4;
    localparam int S_ERR   = 5;
    localparam int S_SCNT  = 6;
    localparam int S_RDATA = 7;
    localparam int S_HI    = 8;
    localparam int S_LO    = 9;
    localparam int S_BUSY  = 10;
    localparam int S_STATE = 11;
    localparam int S_CNT   = 12;

    logic        clk;
    logic        reset;
    logic        req;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_uses_md;
    logic [31:0] e_md_rdata;
    logic        d_stall;
    logic        md_err;
    logic [31:0] stall_cycles;
    logic        force_busy;

    md_issue_ctrl_if md();

    md_issue_ctrl #(
        .MULT_LAT (MLAT),
        .DIV_LAT  (DLAT),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .e_valid      (e_valid),
        .e_op         (e_op),
        .e_rs         (e_rs),
        .e_rt         (e_rt),
        .d_uses_md    (d_uses_md),
        .md           (md),
        .e_md_rdata   (e_md_rdata),
        .d_stall      (d_stall),
        .md_err       (md_err),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural MD unit ----------------
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    function automatic logic [63:0] md_calc(
        input logic [2:0] op,
        input logic [31:0] a,
        input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        sa = $signed(a);
        sb = $signed(b);
        qa = $signed(a);
        qb = $signed(b);
        case (op)
            3'd1: return sa * sb;
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return 64'd0;
                return {32'(qa % qb), 32'(qa / qb)};
            end
            3'd4: begin
                if (b == 32'd0) return 64'd0;
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
        end else begin
            if (md.md_start) begin
                m_busy <= 1'b1;
                m_cnt  <= (md.md_op >= 3'd3) ? DLAT : MLAT;
                {p_hi, p_lo} <= md_calc(md.md_op,
                                        md.md_a, md.md_b);
            end else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end
            end
            if (md.md_mthi) m_hi <= md.md_a;
            if (md.md_mtlo) m_lo <= md.md_a;
        end
    end

    assign md.md_busy = m_busy | force_busy;
    assign md.md_hi   = m_hi;
    assign md.md_lo   = m_lo;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        logic [5:0]  code;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    chk_t chk_q[$];
    cmd_t cmd_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_START: return {31'd0, md.md_start};
            S_OP:    return {29'd0, md.md_op};
            S_MTHI:  return {31'd0, md.md_mthi};
            S_MTLO:  return {31'd0, md.md_mtlo};
            S_STALL: return {31'd0, d_stall};
            S_ERR:   return {31'd0, md_err};
            S_SCNT:  return stall_cycles;
            S_RDATA: return e_md_rdata;
            S_HI:    return md.md_hi;
            S_LO:    return md.md_lo;
            S_BUSY:  return {31'd0, md.md_busy};
            S_STATE: return {31'd0, dut.state_q};
            S_CNT:   return {28'd0, dut.cnt_q};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Command monitor plus timed checks, both on the falling edge
    always @(negedge clk) begin
        logic [5:0]  act_code;
        cmd_t        c;
        logic [31:0] act;
        if (md.md_start | md.md_mthi | md.md_mtlo) begin
            act_code = {md.md_start, md.md_mthi,
                        md.md_mtlo, md.md_op};
            compared++;
            if (cmd_q.size() == 0) begin
                mismatched++;
                $display("FAIL cmd_unexpected cyc=%0d got=%b",
                         cyc, act_code);
            end else begin
                c = cmd_q.pop_front();
                if (act_code !== c.code || md.md_a !== c.a
                    || md.md_b !== c.b) begin
                    mismatched++;
                    $display({"FAIL cmd cyc=%0d got=%b/%h/%h",
                              " exp=%b/%h/%h"}, cyc, act_code,
                             md.md_a, md.md_b, c.code, c.a, c.b);
                end
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc <= cyc) begin
                act = sample(chk_q[i].sel);
                compared++;
                if (chk_q[i].cyc != cyc
                    || act !== chk_q[i].exp) begin
                    mismatched++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h",
                             chk_q[i].name, chk_q[i].cyc,
                             act, chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic ex(input int c, input int sel,
                      input logic [31:0] v, input string n);
        chk_t k;
        k.cyc  = c;
        k.sel  = sel;
        k.exp  = v;
        k.name = n;
        chk_q.push_back(k);
    endtask

    task automatic cmd(input logic [5:0] code,
                       input logic [31:0] a,
                       input logic [31:0] b);
        cmd_t k;
        k.code = code;
        k.a    = a;
        k.b    = b;
        cmd_q.push_back(k);
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        e_valid = v;
        e_op    = op;
        e_rs    = a;
        e_rt    = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int t;

    initial begin
        reset      = 1'b1;
        req        = 1'b0;
        d_uses_md  = 1'b0;
        force_busy = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);

        // Reset state
        step();
        t = cyc;
        ex(t, S_START, 0, "rst_start");
        ex(t, S_STALL, 0, "rst_stall");
        ex(t, S_ERR,   0, "rst_err");
        ex(t, S_SCNT,  0, "rst_scnt");
        ex(t, S_STATE, 0, "rst_state");
        ex(t, S_CNT,   0, "rst_cnt");
        step();
        reset = 1'b0;
        step();

        // mult 7 * -3
        t = cyc;
        d_uses_md = 1'b1;
        drive(1'b1, 4'd1, 32'd7, 32'hFFFF_FFFD);
        cmd(6'b100_001, 32'd7, 32'hFFFF_FFFD);
        ex(t,     S_STALL, 1, "mul_stall_t");
        ex(t + 1, S_START, 0, "mul_start_t1");
        ex(t + 1, S_CNT,   MLAT, "mul_cnt_t1");
        ex(t + 1, S_BUSY,  1, "mul_busy_t1");
        ex(t + 5, S_STALL, 1, "mul_stall_t5");
        ex(t + 5, S_CNT,   1, "mul_cnt_t5");
        ex(t + 6, S_STALL, 0, "mul_stall_t6");
        ex(t + 6, S_STATE, 0, "mul_state_t6");
        ex(t + 6, S_LO, 32'hFFFF_FFEB, "mul_lo");
        ex(t + 6, S_HI, 32'hFFFF_FFFF, "mul_hi");
        ex(t + 6, S_ERR, 0, "mul_err");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        wait_cyc(t + 7);

        // divu 100 / 7 with d_uses_md held high
        do_reset();
        t = cyc;
        d_uses_md = 1'b1;
        drive(1'b1, 4'd4, 32'd100, 32'd7);
        cmd(6'b100_100, 32'd100, 32'd7);
        ex(t,      S_STALL, 1, "divu_stall_t");
        ex(t + 10, S_STALL, 1, "divu_stall_t10");
        ex(t + 11, S_STALL, 0, "divu_stall_t11");
        ex(t + 11, S_LO, 32'd14, "divu_lo");
        ex(t + 11, S_HI, 32'd2, "divu_hi");
        ex(t + 11, S_SCNT, 32'd11, "divu_scnt");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        wait_cyc(t + 12);

        // mthi -> mfhi, mtlo -> mflo, no stall
        t = cyc;
        drive(1'b1, 4'd5, 32'h1234_5678, 32'd0);
        cmd(6'b010_000, 32'h1234_5678, 32'd0);
        ex(t, S_STALL, 0, "mthi_stall");
        step();
        drive(1'b1, 4'd7, 32'd0, 32'd0);
        ex(t + 1, S_RDATA, 32'h1234_5678, "mfhi_rdata");
        ex(t + 1, S_STALL, 0, "mfhi_stall");
        ex(t + 1, S_STATE, 0, "mthi_state");
        step();
        drive(1'b1, 4'd6, 32'hCAFE_F00D, 32'd0);
        cmd(6'b001_000, 32'hCAFE_F00D, 32'd0);
        step();
        drive(1'b1, 4'd8, 32'd0, 32'd0);
        ex(t + 3, S_RDATA, 32'hCAFE_F00D, "mflo_rdata");
        ex(t + 3, S_SCNT, 32'd11, "mt_scnt");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();

        // mult under flush: no command
        t = cyc;
        req = 1'b1;
        drive(1'b1, 4'd1, 32'd5, 32'd5);
        ex(t,     S_START, 0, "req_start");
        ex(t,     S_STALL, 0, "req_stall");
        ex(t + 1, S_STATE, 0, "req_state");
        ex(t + 1, S_BUSY,  0, "req_busy");
        step();
        req = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();

        // signed div -100 / 7 with req pulse at T+2
        t = cyc;
        drive(1'b1, 4'd3, 32'hFFFF_FF9C, 32'd7);
        cmd(6'b100_011, 32'hFFFF_FF9C, 32'd7);
        ex(t + 10, S_STATE, 1, "div_state_t10");
        ex(t + 10, S_BUSY,  1, "div_busy_t10");
        ex(t + 11, S_STATE, 0, "div_state_t11");
        ex(t + 11, S_BUSY,  0, "div_busy_t11");
        ex(t + 11, S_LO, 32'hFFFF_FFF2, "div_lo");
        ex(t + 11, S_HI, 32'hFFFF_FFFE, "div_hi");
        ex(t + 11, S_ERR, 0, "div_err");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        wait_cyc(t + 12);

        // Back-to-back mult: second issues at T+6
        t = cyc;
        drive(1'b1, 4'd2, 32'd3, 32'd4);
        cmd(6'b100_010, 32'd3, 32'd4);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        wait_cyc(t + 6);
        drive(1'b1, 4'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        cmd(6'b100_001, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        ex(t + 6,  S_LO,    32'd12, "b2b_lo1");
        ex(t + 6,  S_BUSY,  0, "b2b_busy");
        ex(t + 6,  S_STALL, 1, "b2b_stall");
        ex(t + 7,  S_STATE, 1, "b2b_state");
        ex(t + 7,  S_CNT,   MLAT, "b2b_cnt");
        ex(t + 12, S_LO,    32'd6, "b2b_lo2");
        ex(t + 12, S_HI,    32'd0, "b2b_hi2");
        ex(t + 12, S_STATE, 0, "b2b_idle");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        wait_cyc(t + 13);

        // Forced busy while idle -> sticky error
        t = cyc;
        force_busy = 1'b1;
        ex(t,     S_ERR, 0, "fb_err_t");
        ex(t + 1, S_ERR, 1, "fb_err_t1");
        ex(t + 3, S_ERR, 1, "fb_err_held");
        step();
        force_busy = 1'b0;
        wait_cyc(t + 4);

        // mtlo during WAIT, then reset mid-WAIT
        do_reset();
        t = cyc;
        drive(1'b1, 4'd1, 32'd2, 32'd2);
        cmd(6'b100_001, 32'd2, 32'd2);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        drive(1'b1, 4'd6, 32'h0000_DEAD, 32'd0);
        ex(t + 2, S_MTLO, 0, "wmt_mtlo");
        ex(t + 2, S_ERR,  0, "wmt_err_t2");
        ex(t + 3, S_ERR,  1, "wmt_err_t3");
        ex(t + 3, S_LO,   0, "wmt_lo");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        reset = 1'b1;
        drive(1'b1, 4'd1, 32'd9, 32'd9);
        ex(t + 4, S_STATE, 0, "mr_state");
        ex(t + 4, S_CNT,   0, "mr_cnt");
        ex(t + 4, S_ERR,   0, "mr_err");
        ex(t + 4, S_START, 0, "mr_start");
        ex(t + 4, S_OP,    0, "mr_op");
        ex(t + 4, S_STALL, 0, "mr_stall");
        ex(t + 4, S_SCNT,  0, "mr_scnt");
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        reset = 1'b0;
        step();
        step();

        compared++;
        if (chk_q.size() != 0) begin
            mismatched++;
            $display("FAIL chk_left got=%0d exp=0", chk_q.size());
        end
        compared++;
        if (cmd_q.size() != 0) begin
            mismatched++;
            $display("FAIL cmd_left got=%0d exp=0", cmd_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
